// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
// Parity bit and PARITY state are built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
  parameter int FREQUENCY  = 50_000_000,
  parameter int SPEED      = 1_500_000,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 CLK_i,
  input  logic                 reset_n,
  input  logic                 dataReady,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 rts
);

  // state   | meaning
  // S_IDLE  | line high, rts high, waiting for dataReady
  // S_START | start bit (tx=0) for one bit time
  // S_DATA  | data bits, LSB first, shift register drains right
  // S_PARITY| parity bit (only with UART_TX_PARITY_EN)
  // S_STOP  | STOP_BITS bit times of tx=1, then back to idle

  localparam int DIVIDER = FREQUENCY / SPEED;
  localparam int CNT_W   = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;

  if (DIVIDER < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_check
    $error("uart_tx_frame: illegal parameter set");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  logic parity_bit;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state;
  logic [CNT_W-1:0]     baud;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_end;

  assign bit_end = (baud == CNT_W'(DIVIDER - 1));

  always_ff @(posedge CLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      tx       <= 1'b1;
      rts      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // Inside a frame the divider free-runs; every bit is exactly DIVIDER cycles.
      if (state == S_IDLE) baud <= '0;
      else if (bit_end)    baud <= '0;
      else                 baud <= baud + 1'b1;

      case (state)
        S_IDLE: begin
          if (dataReady && rts) begin
            shift <= data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^data) ^ 1'(PARITY_ODD);
`endif
            state <= S_START;
            tx    <= 1'b0;
            rts   <= 1'b0;
          end else begin
            tx  <= 1'b1;
            rts <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            tx      <= shift[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= parity_bit;
`else
              state    <= S_STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state <= S_IDLE;
              rts   <= 1'b1;
              tx    <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          rts   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four instances (8N1, 8x2 even, 8x2 odd, 7N1) at DIVIDER=10,
// scoreboard of expected line bits and rts-low lengths. Follows UART_TX_PARITY_EN if defined.
module tb_uart_tx_frame;
  localparam int D = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dr = '0;
  logic [3:0] tx;
  logic [3:0] rts;
  logic [7:0] dat [4];

  logic obs_q [$];
  logic exp_q [$];
  int   len_q [$];
  int   obs_len;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  uart_tx_frame #(.FREQUENCY(50_000_000), .SPEED(5_000_000), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0))
    u0 (.CLK_i(clk), .reset_n(rst_n), .dataReady(dr[0]), .data(dat[0]), .tx(tx[0]), .rts(rts[0]));
  uart_tx_frame #(.FREQUENCY(50_000_000), .SPEED(5_000_000), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0))
    u1 (.CLK_i(clk), .reset_n(rst_n), .dataReady(dr[1]), .data(dat[1]), .tx(tx[1]), .rts(rts[1]));
  uart_tx_frame #(.FREQUENCY(50_000_000), .SPEED(5_000_000), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1))
    u2 (.CLK_i(clk), .reset_n(rst_n), .dataReady(dr[2]), .data(dat[2]), .tx(tx[2]), .rts(rts[2]));
  uart_tx_frame #(.FREQUENCY(50_000_000), .SPEED(5_000_000), .DATA_BITS(7), .STOP_BITS(1), .PARITY_ODD(0))
    u3 (.CLK_i(clk), .reset_n(rst_n), .dataReady(dr[3]), .data(dat[3][6:0]), .tx(tx[3]), .rts(rts[3]));

  function automatic int ubits(input int u);
    return (u == 3) ? 7 : 8;
  endfunction
  function automatic int ustop(input int u);
    return (u == 1 || u == 2) ? 2 : 1;
  endfunction
  function automatic logic uodd(input int u);
    return (u == 2);
  endfunction
  function automatic int flen(input int u);
    return 1 + ubits(u) + P + ustop(u);
  endfunction

  // Expected line bits and rts-low length, recorded as the word is offered.
  task automatic push_frame(input int u, input logic [7:0] w);
    logic par;
    par = uodd(u);
    exp_q.push_back(1'b0);
    for (int i = 0; i < ubits(u); i++) begin
      exp_q.push_back(w[i]);
      par = par ^ w[i];
    end
    if (P == 1) exp_q.push_back(par);
    for (int i = 0; i < ustop(u); i++) exp_q.push_back(1'b1);
    len_q.push_back(flen(u) * D);
  endtask

  // Offers w on unit u; returns #1 after the accepting edge with dataReady still high.
  task automatic start_frame(input int u, input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (rts[u] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL rts_wait unit%0d got rts=%b want 1", u, rts[u]);
    end
    dat[u] = w;
    dr[u]  = 1'b1;
    push_frame(u, w);
    @(posedge clk);
    #1;
  endtask

  // Samples tx mid-bit after acceptance and measures cycles until rts returns high.
  task automatic capture(input int u);
    obs_len = -1;
    for (int c = 1; c <= flen(u) * D + 20; c++) begin
      @(posedge clk);
      #1;
      if ((c % D) == D / 2 && (c / D) < flen(u)) obs_q.push_back(tx[u]);
      if (rts[u] === 1'b1) begin
        obs_len = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dr    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx, rts} !== 8'hff) begin
      errors++;
      $display("FAIL reset_in tx=%b rts=%b want 1111 1111", tx, rts);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({tx, rts} !== 8'hff) begin
        errors++;
        $display("FAIL reset_idle cycle%0d tx=%b rts=%b want 1111 1111", c, tx, rts);
      end
    end
  endtask

  task automatic test_8n1();
    int n;
    logic e, o;
    start_frame(0, 8'hA5);
    dr[0] = 1'b0;
    capture(0);
    n = len_q.pop_front();
    checks++;
    if (obs_len !== n) begin
      errors++;
      $display("FAIL 8n1_rts_low got %0d want %0d", obs_len, n);
    end
    for (int k = 0; k < flen(0); k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL 8n1_bit%0d got %b want %b", k, o, e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_stop2_parity();
    int n;
    logic e, o;
    for (int u = 1; u <= 2; u++) begin
      start_frame(u, 8'hA5);
      dr[u] = 1'b0;
      capture(u);
      n = len_q.pop_front();
      checks++;
      if (obs_len !== n) begin
        errors++;
        $display("FAIL stop2_rts_low unit%0d got %0d want %0d", u, obs_len, n);
      end
      for (int k = 0; k < flen(u); k++) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL stop2_unit%0d_bit%0d got %b want %b", u, k, o, e);
        end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_7bit();
    int n;
    logic e, o;
    logic [7:0] words [2];
    words[0] = 8'h7F;
    words[1] = 8'h00;
    for (int w = 0; w < 2; w++) begin
      start_frame(3, words[w]);
      dr[3] = 1'b0;
      capture(3);
      n = len_q.pop_front();
      checks++;
      if (obs_len !== n) begin
        errors++;
        $display("FAIL 7bit_rts_low word%0d got %0d want %0d", w, obs_len, n);
      end
      for (int k = 0; k < flen(3); k++) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL 7bit_word%0d_bit%0d got %b want %b", w, k, o, e);
        end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic e, o;
    start_frame(0, 8'h55);
    dat[0] = 8'h0F;
    push_frame(0, 8'h0F);
    for (int f = 0; f < 2; f++) begin
      capture(0);
      n = len_q.pop_front();
      checks++;
      if (obs_len !== n) begin
        errors++;
        $display("FAIL b2b_rts_low frame%0d got %0d want %0d", f, obs_len, n);
      end
      for (int k = 0; k < flen(0); k++) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL b2b_frame%0d_bit%0d got %b want %b", f, k, o, e);
        end
      end
      obs_q.delete();
      if (f == 0) begin
        checks++;
        if (tx[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap tx got %b want 1", tx[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({tx[0], rts[0]} !== 2'b00) begin
          errors++;
          $display("FAIL b2b_accept tx/rts got %b%b want 00", tx[0], rts[0]);
        end
        dr[0] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    logic e, o;
    start_frame(0, 8'hA5);
    dr[0] = 1'b0;
    repeat (35) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx[0], rts[0]} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_async tx/rts got %b%b want 11", tx[0], rts[0]);
    end
    for (int k = 0; k < flen(0); k++) e = exp_q.pop_front();
    n = len_q.pop_front();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(0, 8'h3C);
    dr[0] = 1'b0;
    capture(0);
    n = len_q.pop_front();
    checks++;
    if (obs_len !== n) begin
      errors++;
      $display("FAIL midreset_rts_low got %0d want %0d", obs_len, n);
    end
    for (int k = 0; k < flen(0); k++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midreset_bit%0d got %b want %b", k, o, e);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
    test_reset();
    test_8n1();
    test_stop2_parity();
    test_7bit();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
